checkpoint_ctrl: RTL and testbench

- Initiator side of the free-list checkpoint interface (save_state/save_page, restore_state/restore_page, 8 shadow pages).
- Allocates one shadow page per dispatched branch and drives a one-cycle save pulse to the free list.
- On a branch mispredict, drives a one-cycle restore pulse for that branch's page and reclaims it together with all younger pages.
- Frees correctly-resolved pages in program order.

---
 rtl/checkpoint_ctrl.sv | 143 ++++++++++++++
 tb/tb_checkpoint_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkpoint_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : checkpoint_ctrl
// Purpose  : Branch checkpoint initiator: allocates shadow pages in a circular
//            queue, pulses save/restore to the free list, retires in order.
// Revision : 1.0 - initial release
// ============================================================================
module checkpoint_ctrl #(
    parameter int NUM_PAGES = 8,
    parameter int PAGE_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    output logic              br_ready,
    output logic [PAGE_W-1:0] br_page,
    input  logic              resolve_valid,
    input  logic [PAGE_W-1:0] resolve_page,
    input  logic              resolve_mispredict,
    output logic              save_state,
    output logic [PAGE_W-1:0] save_page,
    output logic              restore_state,
    output logic [PAGE_W-1:0] restore_page,
    output logic              busy,
    output logic [PAGE_W:0]   free_count
);

    localparam logic [PAGE_W:0] c_NUM_PAGES = (PAGE_W+1)'(NUM_PAGES);

    logic [PAGE_W:0]        r_head;
    logic [PAGE_W:0]        r_tail;
    logic [NUM_PAGES-1:0]   r_alloc;
    logic [NUM_PAGES-1:0]   r_resolved;
    logic                   r_save_state;
    logic [PAGE_W-1:0]      r_save_page;
    logic                   r_restore_state;
    logic [PAGE_W-1:0]      r_restore_page;
    logic [PAGE_W:0]        r_free_count;

    logic [PAGE_W:0]        w_occupied;
    logic [PAGE_W-1:0]      w_tail_idx;
    logic [PAGE_W-1:0]      w_head_idx;
    logic                   w_mis_req;
    logic                   w_alloc_fire;
    logic                   w_res_hit;
    logic                   w_mis;
    logic                   w_good;
    logic [PAGE_W-1:0]      w_mis_off;
    logic                   w_retire;
    logic [PAGE_W:0]        w_head_nxt;
    logic [PAGE_W:0]        w_tail_nxt;
    logic [NUM_PAGES-1:0]   w_alloc_nxt;
    logic [NUM_PAGES-1:0]   w_resolved_nxt;
    logic [PAGE_W:0]        w_free_nxt;

    assign w_occupied   = r_head - r_tail;
    assign w_tail_idx   = r_tail[PAGE_W-1:0];
    assign w_head_idx   = r_head[PAGE_W-1:0];
    assign w_mis_req    = resolve_valid && resolve_mispredict;
    assign br_ready     = (w_occupied < c_NUM_PAGES) && !r_restore_state && !w_mis_req;
    assign br_page      = w_head_idx;
    assign w_alloc_fire = br_valid && br_ready;
    assign w_res_hit    = resolve_valid && r_alloc[resolve_page];
    assign w_mis        = w_res_hit && resolve_mispredict;
    assign w_good       = w_res_hit && !resolve_mispredict;
    // Distance of the mispredicted page from the oldest live page.
    assign w_mis_off    = resolve_page - w_tail_idx;
    // A mispredict of the tail page empties the queue, so it must not also retire.
    assign w_retire     = (w_occupied != '0) && r_resolved[w_tail_idx]
                          && !(w_mis && (w_mis_off == '0));

    always_comb begin
        w_alloc_nxt    = r_alloc;
        w_resolved_nxt = r_resolved;
        w_head_nxt     = r_head;
        w_tail_nxt     = r_tail;

        if (w_retire) begin
            w_alloc_nxt[w_tail_idx]    = 1'b0;
            w_resolved_nxt[w_tail_idx] = 1'b0;
            w_tail_nxt                 = r_tail + 1'b1;
        end

        if (w_good) begin
            w_resolved_nxt[resolve_page] = 1'b1;
        end

        if (w_mis) begin
            w_head_nxt = r_tail + {1'b0, w_mis_off};
            for (int i = 0; i < NUM_PAGES; i++) begin
                if (PAGE_W'(PAGE_W'(i) - w_tail_idx) >= w_mis_off) begin
                    w_alloc_nxt[i]    = 1'b0;
                    w_resolved_nxt[i] = 1'b0;
                end
            end
        end

        if (w_alloc_fire) begin
            w_alloc_nxt[w_head_idx]    = 1'b1;
            w_resolved_nxt[w_head_idx] = 1'b0;
            w_head_nxt                 = r_head + 1'b1;
        end
    end

    assign w_free_nxt = c_NUM_PAGES - (w_head_nxt - w_tail_nxt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_alloc         <= '0;
            r_resolved      <= '0;
            r_save_state    <= 1'b0;
            r_save_page     <= '0;
            r_restore_state <= 1'b0;
            r_restore_page  <= '0;
            r_free_count    <= c_NUM_PAGES;
        end else begin
            r_head          <= w_head_nxt;
            r_tail          <= w_tail_nxt;
            r_alloc         <= w_alloc_nxt;
            r_resolved      <= w_resolved_nxt;
            r_save_state    <= w_alloc_fire;
            r_restore_state <= w_mis;
            r_free_count    <= w_free_nxt;
            if (w_alloc_fire) begin
                r_save_page <= w_head_idx;
            end
            if (w_mis) begin
                r_restore_page <= resolve_page;
            end
        end
    end

    assign save_state    = r_save_state;
    assign save_page     = r_save_page;
    assign restore_state = r_restore_state;
    assign restore_page  = r_restore_page;
    assign busy          = r_restore_state;
    assign free_count    = r_free_count;

endmodule
`default_nettype wire

// File: tb/tb_checkpoint_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_checkpoint_ctrl
// Purpose  : Self-checking bench for checkpoint_ctrl with save/restore scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_checkpoint_ctrl;

    logic       clk;
    logic       reset;
    logic       br_valid;
    logic       br_ready;
    logic [2:0] br_page;
    logic       resolve_valid;
    logic [2:0] resolve_page;
    logic       resolve_mispredict;
    logic       save_state;
    logic [2:0] save_page;
    logic       restore_state;
    logic [2:0] restore_page;
    logic       busy;
    logic [3:0] free_count;

    typedef struct {
        int page;
        int cyc;
    } ev_t;

    ev_t sq[$];
    ev_t rq[$];
    ev_t se;
    ev_t re;
    int  cyc;
    int  total;
    int  bad;

    checkpoint_ctrl #(.NUM_PAGES(8), .PAGE_W(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .br_valid           (br_valid),
        .br_ready           (br_ready),
        .br_page            (br_page),
        .resolve_valid      (resolve_valid),
        .resolve_page       (resolve_page),
        .resolve_mispredict (resolve_mispredict),
        .save_state         (save_state),
        .save_page          (save_page),
        .restore_state      (restore_state),
        .restore_page       (restore_page),
        .busy               (busy),
        .free_count         (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Pulse scoreboard: each expected pulse must appear exactly one cycle after its request.
    always @(negedge clk) begin
        if (reset) begin
            chk("save_restore_excl", {31'd0, save_state & restore_state}, 0);
            if (save_state) begin
                if (sq.size() == 0) begin
                    chk("save_unexpected", 1, 0);
                end else begin
                    se = sq.pop_front();
                    chk("save_page", save_page, se.page);
                    chk("save_latency", cyc, se.cyc + 1);
                end
            end else if (sq.size() > 0 && sq[0].cyc + 1 <= cyc) begin
                chk("save_missing", 0, 1);
                void'(sq.pop_front());
            end
            if (restore_state) begin
                if (rq.size() == 0) begin
                    chk("restore_unexpected", 1, 0);
                end else begin
                    re = rq.pop_front();
                    chk("restore_page", restore_page, re.page);
                    chk("restore_latency", cyc, re.cyc + 1);
                end
            end else if (rq.size() > 0 && rq[0].cyc + 1 <= cyc) begin
                chk("restore_missing", 0, 1);
                void'(rq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        br_valid      = 1'b0;
        resolve_valid = 1'b0;
        resolve_mispredict = 1'b0;
        resolve_page  = '0;
        sq.delete();
        rq.delete();
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic alloc(input int pg);
        br_valid = 1'b1;
        #1;
        chk("alloc_ready", br_ready, 1);
        chk("alloc_page", br_page, pg);
        sq.push_back('{pg, cyc});
        step();
        br_valid = 1'b0;
    endtask

    task automatic resolve(input int pg, input bit misp, input bit exp_restore);
        resolve_valid      = 1'b1;
        resolve_page       = 3'(pg);
        resolve_mispredict = misp;
        #1;
        if (exp_restore) rq.push_back('{pg, cyc});
        step();
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;

        // Reset / idle
        do_reset();
        #1;
        chk("idle_ready", br_ready, 1);
        chk("idle_free", free_count, 8);
        chk("idle_save", save_state, 0);
        chk("idle_restore", restore_state, 0);
        chk("idle_busy", busy, 0);
        chk("idle_page", br_page, 0);

        // Fill all eight pages back-to-back, then push against full
        for (int p = 0; p < 8; p++) alloc(p);
        br_valid = 1'b1;
        #1;
        chk("full_ready", br_ready, 0);
        chk("full_free", free_count, 0);
        step();
        br_valid = 1'b0;
        step();
        chk("full_free_hold", free_count, 0);

        // Out-of-order correct resolves retire in program order
        do_reset();
        for (int p = 0; p < 5; p++) alloc(p);
        chk("ooo_free0", free_count, 3);
        resolve(3, 0, 0);
        resolve(1, 0, 0);
        resolve(0, 0, 0);
        chk("ooo_free_a", free_count, 3);
        step();
        chk("ooo_free_b", free_count, 4);
        step();
        chk("ooo_free_c", free_count, 5);
        step();
        chk("ooo_free_stop", free_count, 5);
        resolve(2, 0, 0);
        step();
        chk("ooo_free_d", free_count, 6);
        step();
        chk("ooo_free_e", free_count, 7);
        step();
        chk("ooo_free_f", free_count, 7);
        chk("ooo_page", br_page, 5);

        // Mispredict collides with a dispatch: mispredict wins
        do_reset();
        for (int p = 0; p < 6; p++) alloc(p);
        br_valid = 1'b1;
        resolve_valid = 1'b1;
        resolve_page = 3'd2;
        resolve_mispredict = 1'b1;
        #1;
        chk("mis_block_ready", br_ready, 0);
        rq.push_back('{2, cyc});
        step();
        br_valid = 1'b0;
        resolve_valid = 1'b0;
        resolve_mispredict = 1'b0;
        #1;
        chk("mis_restore", restore_state, 1);
        chk("mis_restore_page", restore_page, 2);
        chk("mis_busy", busy, 1);
        chk("mis_free", free_count, 6);
        chk("mis_ready_busy", br_ready, 0);
        step();
        chk("mis_busy_clear", busy, 0);
        alloc(2);
        alloc(3);
        chk("mis_free_after", free_count, 4);

        // Wrap-around, then mispredict of the tail page
        do_reset();
        for (int p = 0; p < 8; p++) alloc(p);
        for (int p = 0; p < 7; p++) resolve(p, 0, 0);
        step();
        step();
        chk("wrap_free", free_count, 7);
        alloc(0);
        alloc(1);
        alloc(2);
        chk("wrap_free2", free_count, 4);
        resolve(7, 1, 1);
        #1;
        chk("wrap_restore_page", restore_page, 7);
        chk("wrap_free_empty", free_count, 8);
        chk("wrap_page", br_page, 7);
        step();
        chk("wrap_ready", br_ready, 1);
        alloc(7);

        // Reset asserted during a save pulse
        do_reset();
        for (int p = 0; p < 5; p++) alloc(p);
        chk("pre_rst_save", save_state, 1);
        reset = 1'b0;
        sq.delete();
        rq.delete();
        #1;
        chk("rst_save_drop", save_state, 0);
        chk("rst_free", free_count, 8);
        step();
        reset = 1'b1;
        resolve(3, 0, 0);
        resolve(3, 1, 0);
        step();
        chk("rst_ign_free", free_count, 8);
        chk("rst_ign_page", br_page, 0);
        chk("rst_ign_restore", restore_state, 0);
        alloc(0);
        step();
        step();

        chk("sq_drained", sq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
